// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings and constants for the elastic pipeline-stage buffer.
package pipe_pkg;
  // The encoding doubles as the entry count held by the stage.
  typedef enum logic [1:0] {ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_SKIDF = 2'b10} state_t;
  localparam logic [63:0] CTRL_NOP = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: statistics counter that adds 0..3 per cycle and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);
  logic [W:0] sum;
  assign sum = {1'b0, count} + {{(W - 1){1'b0}}, inc};
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else count <= sum[W] ? '1 : sum[W-1:0];
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready stage register with optional skid entry,
// synchronous flush, NOP control on bubbles and saturating stall/drop statistics.
module pipe_stage_buf import pipe_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_drop_cnt
);
  state_t state, state_nx;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic in_fire, out_fire, load_in, load_skid, load_fwd;
  logic [1:0] drop_inc;
  assign out_valid = state != ST_EMPTY;
  // With a skid entry, ready depends only on the registered state.
  assign in_ready  = SKID != 0 ? state != ST_SKIDF : !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_W'(CTRL_NOP);
  assign occupancy = state;
  assign drop_inc  = flush ? occupancy - {1'b0, out_fire} : 2'd0;
  always_comb begin
    state_nx  = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    load_fwd  = 1'b0;
    if (flush) state_nx = ST_EMPTY;
    else if (state == ST_EMPTY) begin
      load_in  = in_fire;
      state_nx = in_fire ? ST_FULL : ST_EMPTY;
    end else if (state == ST_FULL) begin
      load_in   = in_fire && out_fire;
      load_skid = in_fire && !out_fire;
      state_nx  = load_skid ? ST_SKIDF : (!in_fire && out_fire) ? ST_EMPTY : ST_FULL;
    end else begin
      load_fwd = out_fire;
      state_nx = out_fire ? ST_FULL : ST_SKIDF;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nx;
      if (load_in) {main_data, main_ctrl} <= {in_data, in_ctrl};
      else if (load_fwd) {main_data, main_ctrl} <= {skid_data, skid_ctrl};
      if (load_skid) {skid_data, skid_ctrl} <= {in_data, in_ctrl};
    end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .clr(clr_stats),
    .inc({1'b0, out_valid && !out_ready}), .count(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_drop (
    .clk(clk), .rst(rst), .clr(clr_stats),
    .inc(drop_inc), .count(flush_drop_cnt)
  );
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register for the 16-bit pipelined core. It replaces the fixed per-stage latch modules (fetch/decode/execute/memory) with one generic block. It carries a data payload and a control payload through a valid/ready handshake, with an optional 2-entry skid buffer, synchronous flush, bubble insertion that forces control to NOP, and saturating stall/flush statistics counters. One instance per stage boundary; width and control fields are set per instance.

Parameters:
DATA_W, 16, payload width (operands, PC, immediate, etc.)
CTRL_W, 8, control-field width (writeReg, writeMem, load, branch, ...); forced to 0 when the stage holds a bubble
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready pass-through
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous flush; empties the stage
clr_stats  in  1  synchronous clear of both counters
in_valid  in  1  upstream has a valid entry
in_ready  out  1  stage accepts an entry this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  stage holds a valid entry
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  head payload
out_ctrl  out  CTRL_W  head control; 0 when out_valid=0
occupancy  out  2  number of held entries, 0..2
stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready
flush_drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Reset (async): state EMPTY; main/skid registers, counters and occupancy = 0; out_valid=0; out_ctrl=0; in_ready=1.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency is 1 cycle from in_fire to out_valid. Sustained throughput is 1 entry/cycle.
- out_data is driven from the main register. out_ctrl = out_valid ? main_ctrl : 0. While out_valid=0, out_data holds its last value and is don't-care.
- SKID=1 FSM (in_ready is registered: 1 in EMPTY and FULL, 0 in SKIDF):
  - EMPTY: in_fire -> FULL, main <= in.
  - FULL: in_fire & out_fire -> FULL, main <= in. in_fire & !out_fire -> SKIDF, skid <= in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - SKIDF: out_fire -> FULL, main <= skid. Otherwise hold. No input is accepted in SKIDF.
- SKID=0: states are EMPTY and FULL only. in_ready = !out_valid | out_ready (combinational). SKIDF is unreachable and occupancy never exceeds 1.
- Flush: highest priority after rst. Next state is EMPTY and occupancy becomes 0.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered.
  - flush_drop_cnt increments by (occupancy − out_fire), i.e. the entries held but not delivered, saturating.
- stall_cnt increments every cycle with out_valid & !out_ready, including the flush cycle. It saturates at all-ones and does not wrap.
- clr_stats zeroes both counters and takes priority over an increment in the same cycle.
- Reset mid-operation: everything in flight is discarded immediately; no counter records the loss.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_ctrl must not change.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings ST_EMPTY=2'b00, ST_FULL=2'b01, ST_SKIDF=2'b10;
  - CTRL_NOP constant (all zeros).
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc[1:0], count). It is instantiated twice, for stall_cnt and flush_drop_cnt.

Test Plan:
- Streaming, SKID=1, out_ready=1: in_data 0x0001..0x0008 on consecutive cycles -> out_data identical sequence starting 1 cycle later, no gaps, stall_cnt=0.
- Backpressure: fill with 0x00A1, 0x00A2, then out_ready=0 for 5 cycles -> occupancy=2, in_ready=0 from the cycle after the 2nd accept, stall_cnt=5. Release -> 0x00A1 then 0x00A2 delivered in order, no loss or duplication.
- Flush while SKIDF, out_ready=0 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_drop_cnt=2. Concurrent in_valid with 0x00FF never appears at the output.
- Bubble control: in_ctrl=8'hFF, in_valid=0 for 3 cycles -> out_ctrl=8'h00 throughout. One valid entry with ctrl 8'h5A -> out_ctrl=8'h5A for exactly one cycle.
- SKID=0: out_ready low then high in the same cycle as new input -> in_ready tracks out_ready combinationally, occupancy never exceeds 1, order preserved.
- Saturation/reset: CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15 (no wrap). clr_stats -> 0. Assert rst mid-stream -> outputs at reset values without waiting for a clock edge.
